// File: rtl/mux_pkg.sv
// Shared occupancy type and select-width helper for the N:1 select stages.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Every stage that carries a select index sizes it through this one helper.
  function automatic int sel_w(input int num_in);
    return (num_in < 2) ? 1 : $clog2(num_in);
  endfunction

endpackage

// File: rtl/mux_n_1.sv
// Combinational WIDTH-bit N:1 multiplexer; a select at or beyond NUM_IN yields all zeros.
module mux_n_1
  import mux_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN*WIDTH-1:0]  in_data,
  input  logic [sel_w(NUM_IN)-1:0] sel,
  output logic [WIDTH-1:0]         out_data
);

  always_comb begin
    out_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel) == k) begin
        out_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_n_1_pipe.sv
// Registered N:1 select stage with ready/valid handshake and a 2-entry skid buffer.
// Optional out-of-range select checking is built when MUX_N_1_PIPE_SELCHK_EN is defined.
module mux_n_1_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [sel_w(NUM_IN)-1:0]  sel,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [sel_w(NUM_IN)-1:0]  out_sel,
  output logic                      sel_err
);

  localparam int SEL_W = sel_w(NUM_IN);

  occ_e             state_q, state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] main_data_q, skid_data_q, pick_data;
  logic [SEL_W-1:0] main_sel_q, skid_sel_q;
  logic             accept, emit;
  logic             load_main, load_skid, skid_to_main;

  mux_n_1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_pick (
    .in_data  (in_data),
    .sel      (sel),
    .out_data (pick_data)
  );

  assign accept    = in_valid && in_ready_q;
  assign emit      = out_valid && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;

  // Flush overrides everything; otherwise main always holds the oldest entry.
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && emit) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (emit) begin
            state_d      = ONE;
            skid_to_main = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready is its own flop so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
    end else begin
      if (load_main) begin
        main_data_q <= pick_data;
        main_sel_q  <= sel;
      end else if (skid_to_main) begin
        main_data_q <= skid_data_q;
        main_sel_q  <= skid_sel_q;
      end
      if (load_skid) begin
        skid_data_q <= pick_data;
        skid_sel_q  <= sel;
      end
    end
  end

`ifdef MUX_N_1_PIPE_SELCHK_EN
  logic sel_oor;
  logic sel_err_q;

  // Only accepts that survive a flush count as out-of-range events.
  assign sel_oor = (int'(sel) >= NUM_IN);
  assign sel_err = sel_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else if (accept && !flush && sel_oor) begin
      sel_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && accept && !flush) begin
      assert (!sel_oor)
      else $warning("mux_n_1_pipe: select %0d out of range", sel);
    end
  end
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Randomised and directed bench for mux_n_1_pipe against a queue-based reference model.
module tb_mux_n_1_pipe;

  typedef struct {
    logic [4:0] d;
    logic [1:0] s;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  sel = '0;
  logic [19:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_data;
  logic [1:0]  out_sel;
  logic        sel_err;

  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [1:0]  sel3 = '0;
  logic [14:0] in_data3 = '0;
  logic        out_valid3;
  logic        out_ready3 = 1'b1;
  logic [4:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        sel_err3;

  int total = 0;
  int bad = 0;
  item_t q[$];

  always #5 clk = ~clk;

  mux_n_1_pipe #(.WIDTH(5), .NUM_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .sel_err(sel_err)
  );

  mux_n_1_pipe #(.WIDTH(5), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel(sel3), .in_data(in_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_data(out_data3), .out_sel(out_sel3), .sel_err(sel_err3)
  );

  function automatic item_t ref_pick(input logic [19:0] d, input logic [1:0] s);
    item_t it;
    it.s = s;
    it.d = (int'(s) < 4) ? 5'((d >> (5 * int'(s))) & 20'h1f) : 5'd0;
    return it;
  endfunction

  // One clock of the reference: a 2-deep FIFO that pops on emit, pushes on accept.
  task automatic tick();
    bit acc, emt;
    item_t it;
    acc = in_valid && (q.size() < 2);
    emt = (q.size() > 0) && out_ready;
    it  = ref_pick(in_data, sel);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (emt) void'(q.pop_front());
      if (acc) q.push_back(it);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_data !== 5'd0) begin bad++; $display("[TB] FAIL reset_out_data: got %0d want 0", out_data); end
    if (out_sel !== 2'd0) begin bad++; $display("[TB] FAIL reset_out_sel: got %0d want 0", out_sel); end
    if (sel_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_sel_err: got %b want 0", sel_err); end
    #2 rst_n = 1'b1;
    q.delete();
    tick();
  endtask

  task automatic test_streaming();
    in_data   = {5'd3, 5'd2, 5'd1, 5'd0};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      tick();
      total += 3;
      if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream_valid%0d: got %b want 1", k, out_valid); end
      if (out_data !== 5'(k)) begin bad++; $display("[TB] FAIL stream_data%0d: got %0d want %0d", k, out_data, k); end
      if (out_sel !== 2'(k)) begin bad++; $display("[TB] FAIL stream_sel%0d: got %0d want %0d", k, out_sel, k); end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    in_data   = {5'd0, 5'd0, 5'd9, 5'd7};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel = 2'd0; tick();
    sel = 2'd1; tick();
    in_valid = 1'b0;
    total += 3;
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_full_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_full_valid: got %b want 1", out_valid); end
    if (out_data !== 5'd7) begin bad++; $display("[TB] FAIL bp_first: got %0d want 7", out_data); end
    tick();
    total += 2;
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold_ready: got %b want 0", in_ready); end
    if (out_data !== 5'd7) begin bad++; $display("[TB] FAIL bp_hold_data: got %0d want 7", out_data); end
    out_ready = 1'b1;
    tick();
    total += 3;
    if (out_data !== 5'd9) begin bad++; $display("[TB] FAIL bp_second: got %0d want 9", out_data); end
    if (out_sel !== 2'd1) begin bad++; $display("[TB] FAIL bp_second_sel: got %0d want 1", out_sel); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_back: got %b want 1", in_ready); end
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    in_data   = {5'd0, 5'd21, 5'd12, 5'd11};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel = 2'd0; tick();
    sel = 2'd1; tick();
    sel   = 2'd2;
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_leak%0d: got valid %b data %0d want 0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_random();
    item_t exp;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      sel       = 2'($urandom_range(0, 3));
      in_data   = 20'($urandom);
      tick();
      total += 3;
      if (out_valid !== (q.size() > 0)) begin bad++; $display("[TB] FAIL rand_valid@%0d: got %b want %b", i, out_valid, q.size() > 0); end
      if (in_ready !== (q.size() < 2)) begin bad++; $display("[TB] FAIL rand_ready@%0d: got %b want %b", i, in_ready, q.size() < 2); end
      if (sel_err !== 1'b0) begin bad++; $display("[TB] FAIL rand_sel_err@%0d: got %b want 0", i, sel_err); end
      if (q.size() > 0) begin
        exp = q[0];
        total += 2;
        if (out_data !== exp.d) begin bad++; $display("[TB] FAIL rand_data@%0d: got %0d want %0d", i, out_data, exp.d); end
        if (out_sel !== exp.s) begin bad++; $display("[TB] FAIL rand_sel@%0d: got %0d want %0d", i, out_sel, exp.s); end
      end
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_async_reset();
    in_data   = {5'd0, 5'd17, 5'd0, 5'd0};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel = 2'd2;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL areset_pre: got %b want 1", out_valid); end
    #3 rst_n = 1'b0;
    #1;
    q.delete();
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL areset_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL areset_ready: got %b want 1", in_ready); end
    if (out_data !== 5'd0) begin bad++; $display("[TB] FAIL areset_data: got %0d want 0", out_data); end
    #2 rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    sel = 2'd3;
    in_data = {5'd29, 5'd0, 5'd0, 5'd0};
    tick();
    in_valid = 1'b0;
    total += 2;
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL areset_resume_valid: got %b want 1", out_valid); end
    if (out_data !== 5'd29) begin bad++; $display("[TB] FAIL areset_resume_data: got %0d want 29", out_data); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_selchk();
    logic exp_err;
`ifdef MUX_N_1_PIPE_SELCHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    in_data3   = {5'd30, 5'd20, 5'd10};
    out_ready3 = 1'b1;
    in_valid3  = 1'b1;
    sel3 = 2'd3;
    tick();
    total += 3;
    if (out_valid3 !== 1'b1) begin bad++; $display("[TB] FAIL selchk_valid: got %b want 1", out_valid3); end
    if (out_data3 !== 5'd0) begin bad++; $display("[TB] FAIL selchk_zero: got %0d want 0", out_data3); end
    if (sel_err3 !== exp_err) begin bad++; $display("[TB] FAIL selchk_err: got %b want %b", sel_err3, exp_err); end
    for (int k = 0; k < 3; k++) begin
      sel3 = 2'(k);
      tick();
      total += 2;
      if (out_data3 !== 5'(10 * (k + 1))) begin bad++; $display("[TB] FAIL selchk_legal%0d: got %0d want %0d", k, out_data3, 10 * (k + 1)); end
      if (sel_err3 !== exp_err) begin bad++; $display("[TB] FAIL selchk_sticky%0d: got %b want %b", k, sel_err3, exp_err); end
    end
    in_valid3 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    test_selchk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
